// File: rtl/dispatch_rr_scheduler.sv
// Round-robin dispatch arbiter for one shared execute lane. The grant is held from sop to eop
// and admission of new instructions is gated by an in-flight credit counter.
module dispatch_rr_scheduler #(
    parameter int NUM_REQS = 4,
    parameter int CREDITS  = 8,
    localparam int REQ_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int CRD_W   = $clog2(CREDITS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req_valid,
    input  logic [NUM_REQS-1:0] req_sop,
    input  logic [NUM_REQS-1:0] req_eop,
    output logic [NUM_REQS-1:0] req_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [REQ_W-1:0]    grant_idx,
    output logic                locked,
    input  logic                credit_return,
    output logic [CRD_W-1:0]    credits_avail
);

    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDITS);
    localparam logic [REQ_W-1:0] LAST    = REQ_W'(NUM_REQS - 1);

    logic [REQ_W-1:0] rr_ptr, lock_idx, cand_idx, sel_idx, next_ptr;
    logic             lock_r, cand_found, fire, crd_take;
    logic [CRD_W-1:0] credit_cnt;

    // First sop-valid requester at or after rr_ptr, wrapping modulo NUM_REQS.
    always_comb begin
        int j;
        j          = 0;
        cand_idx   = rr_ptr;
        cand_found = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            j = (int'(rr_ptr) + k) % NUM_REQS;
            if (!cand_found && req_valid[j] && req_sop[j]) begin
                cand_idx   = REQ_W'(j);
                cand_found = 1'b1;
            end
        end
    end

    // out_valid is built only from state and request inputs, never from out_ready.
    always_comb begin
        sel_idx   = rr_ptr;
        out_valid = 1'b0;
        if (reset) begin
            sel_idx = '0;
        end else if (lock_r) begin
            sel_idx   = lock_idx;
            out_valid = req_valid[lock_idx];
        end else if (credit_cnt != '0 && cand_found) begin
            sel_idx   = cand_idx;
            out_valid = 1'b1;
        end
    end

    assign grant_idx     = sel_idx;
    assign fire          = out_valid && out_ready;
    assign req_ready     = fire ? (NUM_REQS'(1) << sel_idx) : '0;
    assign locked        = lock_r && !reset;
    assign credits_avail = reset ? CRD_MAX : credit_cnt;
    assign crd_take      = fire && !lock_r;
    assign next_ptr      = (sel_idx == LAST) ? '0 : sel_idx + REQ_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            lock_r     <= 1'b0;
            lock_idx   <= '0;
            credit_cnt <= CRD_MAX;
        end else begin
            if (fire) begin
                if (req_eop[sel_idx]) begin
                    lock_r <= 1'b0;
                    rr_ptr <= next_ptr;
                end else if (!lock_r) begin
                    lock_r   <= 1'b1;
                    lock_idx <= sel_idx;
                end
            end
            // Simultaneous take and return cancel; a surplus return saturates.
            if (crd_take && !credit_return)
                credit_cnt <= credit_cnt - CRD_W'(1);
            else if (credit_return && !crd_take && credit_cnt != CRD_MAX)
                credit_cnt <= credit_cnt + CRD_W'(1);
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
    a_idle_sop:     assert property (@(posedge clk) disable iff (reset)
                                     !(!lock_r && |(req_valid & ~req_sop)));
    a_credit_ovf:   assert property (@(posedge clk) disable iff (reset)
                                     !(credit_return && !crd_take && credit_cnt == CRD_MAX));

endmodule

// File: tb/tb_dispatch_rr_scheduler.sv
// Directed bench for dispatch_rr_scheduler: a queue-free reference model checked every cycle
// plus hand-computed literal expectations along the stimulus.
module tb_dispatch_rr_scheduler;

    localparam int NR      = 4;
    localparam int CREDITS = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR-1:0] req_valid, req_sop, req_eop, req_ready;
    logic          out_valid, out_ready, locked, credit_return;
    logic [1:0]    grant_idx;
    logic [3:0]    credits_avail;

    int checks   = 0;
    int failures = 0;

    dispatch_rr_scheduler #(.NUM_REQS(NR), .CREDITS(CREDITS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_sop(req_sop), .req_eop(req_eop), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready), .grant_idx(grant_idx), .locked(locked),
        .credit_return(credit_return), .credits_avail(credits_avail)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endfunction

    // Reference model: spec rules in plain integer arithmetic, advanced at every negedge.
    int m_ptr = 0, m_idx = 0, m_cred = CREDITS;
    bit m_lock = 0;

    always @(negedge clk) begin : model
        int g, d, er;
        bit v, f;
        if (reset) begin
            chk("m_rst_valid", int'(out_valid), 0);
            chk("m_rst_ready", int'(req_ready), 0);
            chk("m_rst_grant", int'(grant_idx), 0);
            chk("m_rst_locked", int'(locked), 0);
            chk("m_rst_credits", int'(credits_avail), CREDITS);
            m_ptr = 0; m_lock = 0; m_idx = 0; m_cred = CREDITS;
        end else begin
            v = 0;
            g = m_ptr;
            if (m_lock) begin
                g = m_idx;
                v = req_valid[g];
            end else if (m_cred > 0) begin
                for (int k = 0; k < NR; k++)
                    if (!v && req_valid[(m_ptr + k) % NR] && req_sop[(m_ptr + k) % NR]) begin
                        g = (m_ptr + k) % NR;
                        v = 1;
                    end
            end
            f  = v && out_ready;
            er = f ? (1 << g) : 0;
            chk("m_valid", int'(out_valid), int'(v));
            chk("m_grant", int'(grant_idx), g);
            chk("m_ready", int'(req_ready), er);
            chk("m_locked", int'(locked), int'(m_lock));
            chk("m_credits", int'(credits_avail), m_cred);
            d = 0;
            if (f && !m_lock) d = d - 1;
            if (credit_return) d = d + 1;
            m_cred = (m_cred + d > CREDITS) ? CREDITS : m_cred + d;
            if (f) begin
                if (req_eop[g]) begin
                    m_lock = 0;
                    m_ptr  = (g + 1) % NR;
                end else if (!m_lock) begin
                    m_lock = 1;
                    m_idx  = g;
                end
            end
        end
    end

    task automatic set_in(input logic [NR-1:0] v, input logic [NR-1:0] s,
                          input logic [NR-1:0] e, input bit ordy, input bit cr);
        req_valid = v; req_sop = s; req_eop = e; out_ready = ordy; credit_return = cr;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_in(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        mid();
        chk("rst_credits", int'(credits_avail), 8);
        chk("rst_valid", int'(out_valid), 0);
        nxt(); mid(); nxt();
        reset = 1'b0;

        // Single-packet round robin with continuous ready.
        set_in(4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("rr_grant", int'(grant_idx), i % 4);
            chk("rr_credits", int'(credits_avail), 8 - i);
            chk("rr_valid", int'(out_valid), 1);
            nxt();
        end
        set_in(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        repeat (5) begin mid(); nxt(); end
        set_in(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        mid();
        chk("ret_credits", int'(credits_avail), 8);
        chk("idle_grant_ptr1", int'(grant_idx), 1);
        nxt();

        // Four-packet instruction on req1 while req2 waits.
        set_in(4'b0110, 4'b0110, 4'b0100, 1'b1, 1'b0);
        mid();
        chk("mp_grant0", int'(grant_idx), 1);
        chk("mp_unlocked0", int'(locked), 0);
        chk("mp_ready0", int'(req_ready), 2);
        nxt();
        set_in(4'b0110, 4'b0100, 4'b0100, 1'b1, 1'b0);
        repeat (2) begin
            mid();
            chk("mp_grant_mid", int'(grant_idx), 1);
            chk("mp_locked_mid", int'(locked), 1);
            nxt();
        end
        set_in(4'b0110, 4'b0100, 4'b0110, 1'b1, 1'b0);
        mid();
        chk("mp_grant_eop", int'(grant_idx), 1);
        chk("mp_locked_eop", int'(locked), 1);
        nxt();
        set_in(4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b0);
        mid();
        chk("mp_next_grant", int'(grant_idx), 2);
        chk("mp_next_unlocked", int'(locked), 0);
        chk("mp_credits", int'(credits_avail), 7);
        nxt();
        set_in(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        mid();
        chk("mp_ptr_end", int'(grant_idx), 3);
        chk("mp_idle_valid", int'(out_valid), 0);
        nxt();

        // Drain to two credits, then exhaust them with three pending requests.
        set_in(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0);
        repeat (4) begin mid(); chk("drain_grant", int'(grant_idx), 0); nxt(); end
        set_in(4'b1110, 4'b1110, 4'b1110, 1'b1, 1'b0);
        mid(); chk("crd_grant1", int'(grant_idx), 1); chk("crd_avail2", int'(credits_avail), 2); nxt();
        mid(); chk("crd_grant2", int'(grant_idx), 2); chk("crd_avail1", int'(credits_avail), 1); nxt();
        mid(); chk("crd_stall_valid", int'(out_valid), 0); chk("crd_stall_grant", int'(grant_idx), 3);
        chk("crd_avail0", int'(credits_avail), 0); nxt();
        set_in(4'b1110, 4'b1110, 4'b1110, 1'b1, 1'b1);
        mid(); chk("crd_ret_valid", int'(out_valid), 0); chk("crd_ret_avail", int'(credits_avail), 0); nxt();
        set_in(4'b1110, 4'b1110, 4'b1110, 1'b1, 1'b0);
        mid(); chk("crd_resume_valid", int'(out_valid), 1); chk("crd_resume_grant", int'(grant_idx), 3);
        chk("crd_resume_avail", int'(credits_avail), 1); nxt();
        set_in(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        mid(); chk("crd_after_avail", int'(credits_avail), 0); nxt();

        // Return coincident with an idle fire at three credits.
        set_in(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        repeat (3) begin mid(); nxt(); end
        set_in(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1);
        mid(); chk("coin_avail", int'(credits_avail), 3); chk("coin_valid", int'(out_valid), 1);
        chk("coin_grant", int'(grant_idx), 0); nxt();
        set_in(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        mid(); chk("coin_hold", int'(credits_avail), 3); nxt();

        // Locked requester drops valid for three cycles.
        set_in(4'b1100, 4'b1100, 4'b1000, 1'b1, 1'b0);
        mid(); chk("gap_grant0", int'(grant_idx), 2); chk("gap_ready0", int'(req_ready), 4); nxt();
        set_in(4'b1100, 4'b1000, 4'b1000, 1'b1, 1'b0);
        mid(); chk("gap_locked1", int'(locked), 1); nxt();
        set_in(4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0);
        repeat (3) begin
            mid();
            chk("gap_valid", int'(out_valid), 0);
            chk("gap_locked", int'(locked), 1);
            chk("gap_grant", int'(grant_idx), 2);
            chk("gap_ready", int'(req_ready), 0);
            nxt();
        end
        set_in(4'b1100, 4'b1000, 4'b1000, 1'b1, 1'b0);
        mid(); chk("gap_resume", int'(out_valid), 1); chk("gap_resume_grant", int'(grant_idx), 2); nxt();
        set_in(4'b1100, 4'b1000, 4'b1100, 1'b1, 1'b0);
        mid(); chk("gap_eop_ready", int'(req_ready), 4); nxt();
        set_in(4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0);
        mid(); chk("gap_next_grant", int'(grant_idx), 3); chk("gap_next_unlocked", int'(locked), 0);
        chk("gap_credits", int'(credits_avail), 2); nxt();
        set_in(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        mid(); chk("gap_end_avail", int'(credits_avail), 1); chk("gap_end_ptr", int'(grant_idx), 0); nxt();

        // Reset in the middle of a locked instruction.
        set_in(4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0);
        mid(); chk("rl_grant", int'(grant_idx), 1); nxt();
        set_in(4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0);
        mid(); chk("rl_locked", int'(locked), 1); chk("rl_avail0", int'(credits_avail), 0); nxt();
        reset = 1'b1;
        mid(); chk("rl_rst_valid", int'(out_valid), 0); chk("rl_rst_locked", int'(locked), 0);
        chk("rl_rst_avail", int'(credits_avail), 8); chk("rl_rst_ready", int'(req_ready), 0); nxt();
        reset = 1'b0;
        set_in(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        mid(); chk("rl_post_locked", int'(locked), 0); chk("rl_post_ptr", int'(grant_idx), 0);
        chk("rl_post_avail", int'(credits_avail), 8); nxt();
        set_in(4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0);
        mid(); chk("rl_wrap_grant", int'(grant_idx), 3); chk("rl_wrap_ready", int'(req_ready), 8); nxt();
        set_in(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        mid(); chk("rl_final_avail", int'(credits_avail), 7); nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
